// File: rtl/nibble_compare_seq.sv
// Purpose: sequences a wide unsigned compare through one shared 4-bit cascadable comparator slice, MSB nibble first.
// Latency: start edge k -> oDone in cycle k+NIBBLES+2 (with NIBBLE_CMP_EARLY_EXIT_EN: nibbles examined + 2).
// Backpressure: none; iStart is only honoured in IDLE, requests while busy are dropped, not queued.
//
// Optional build macro NIBBLE_CMP_EARLY_EXIT_EN: stop at the first decided nibble instead of
// cascading the decision through the remaining nibbles.
// NIBBLES legal range is 2..16 and 2**IDX_W must be >= NIBBLES.

module nibble_compare_seq #(
    parameter int NIBBLES = 4,
    parameter int IDX_W   = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic [4*NIBBLES-1:0] iData_a,
    input  logic [4*NIBBLES-1:0] iData_b,
    output logic [3:0]           oCmp_a,
    output logic [3:0]           oCmp_b,
    output logic [2:0]           oCmp_cas,
    input  logic [2:0]           iCmp_res,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2:0]           oData,
    output logic                 oErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] RES_EQ = 3'b010;

    state_t               state;
    state_t               state_nxt;
    logic [4*NIBBLES-1:0] op_a;
    logic [4*NIBBLES-1:0] op_b;
    logic [IDX_W-1:0]     idx;
    logic [2:0]           run;

    logic [IDX_W-1:0]     sel_idx;
    logic [4*NIBBLES-1:0] shift_a;
    logic [4*NIBBLES-1:0] shift_b;
    logic                 res_onehot;
    logic                 last_nibble;
    logic                 run_exit;

    // Nibble to present next: in LOAD the top nibble (idx already NIBBLES-1), in RUN the one below idx.
    always_comb begin
        sel_idx     = (state == LOAD) ? idx : (idx - 1'b1);
        shift_a     = op_a >> {sel_idx, 2'b00};
        shift_b     = op_b >> {sel_idx, 2'b00};
        res_onehot  = (iCmp_res == 3'b001) || (iCmp_res == 3'b010) || (iCmp_res == 3'b100);
        last_nibble = (idx == '0);
`ifdef NIBBLE_CMP_EARLY_EXIT_EN
        run_exit    = last_nibble || (iCmp_res != RES_EQ);
`else
        run_exit    = last_nibble;
`endif
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        oBusy     = 1'b0;
        oDone     = 1'b0;
        case (state)
            IDLE: if (iStart) state_nxt = LOAD;
            LOAD: begin
                oBusy     = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                oBusy = 1'b1;
                if (run_exit) state_nxt = DONE;
            end
            DONE: begin
                oDone     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Operand capture, nibble sequencing, cascade feedback and result/error registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            op_a     <= '0;
            op_b     <= '0;
            idx      <= '0;
            run      <= 3'b000;
            oCmp_a   <= 4'h0;
            oCmp_b   <= 4'h0;
            oCmp_cas <= 3'b000;
            oData    <= 3'b000;
            oErr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oCmp_a   <= 4'h0;
                    oCmp_b   <= 4'h0;
                    oCmp_cas <= 3'b000;
                    if (iStart) begin
                        op_a  <= iData_a;
                        op_b  <= iData_b;
                        idx   <= IDX_W'(NIBBLES - 1);
                        run   <= 3'b000;
                        oData <= 3'b000;
                        oErr  <= 1'b0;
                    end
                end
                LOAD: begin
                    oCmp_a   <= shift_a[3:0];
                    oCmp_b   <= shift_b[3:0];
                    oCmp_cas <= 3'b000;
                end
                RUN: begin
                    run <= iCmp_res;
                    if (!res_onehot) oErr <= 1'b1;
                    if (run_exit) begin
                        // run is updated on this same edge, so take the slice result directly
                        // to have oData valid in the cycle oDone is high.
                        oData    <= iCmp_res;
                        oCmp_a   <= 4'h0;
                        oCmp_b   <= 4'h0;
                        oCmp_cas <= 3'b000;
                    end else begin
                        idx    <= idx - 1'b1;
                        oCmp_a <= shift_a[3:0];
                        oCmp_b <= shift_b[3:0];
                        // Equal-so-far must not be fed back: a non-zero cascade makes the
                        // slice pass it through and ignore the lower nibbles.
                        oCmp_cas <= (iCmp_res == RES_EQ) ? 3'b000 : iCmp_res;
                    end
                end
                default: begin
                    oCmp_a   <= 4'h0;
                    oCmp_b   <= 4'h0;
                    oCmp_cas <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_compare_seq.sv
module tb_nibble_compare_seq;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic [15:0] iData_a;
    logic [15:0] iData_b;
    logic [3:0]  oCmp_a;
    logic [3:0]  oCmp_b;
    logic [2:0]  oCmp_cas;
    logic [2:0]  iCmp_res;
    logic        oBusy;
    logic        oDone;
    logic [2:0]  oData;
    logic        oErr;

    int checks   = 0;
    int failures = 0;
    logic fault_en = 1'b0;

    nibble_compare_seq #(.NIBBLES(4), .IDX_W(4)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iStart   (iStart),
        .iData_a  (iData_a),
        .iData_b  (iData_b),
        .oCmp_a   (oCmp_a),
        .oCmp_b   (oCmp_b),
        .oCmp_cas (oCmp_cas),
        .iCmp_res (iCmp_res),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oData    (oData),
        .oErr     (oErr)
    );

    always #5 iClk = ~iClk;

    // Behavioural model of the external 4-bit cascadable slice; optional fault on the nibble value 2.
    always_comb begin
        if (fault_en && oCmp_cas == 3'b000 && oCmp_a == 4'h2) iCmp_res = 3'b011;
        else if (oCmp_cas != 3'b000)                          iCmp_res = oCmp_cas;
        else if (oCmp_a > oCmp_b)                             iCmp_res = 3'b001;
        else if (oCmp_a == oCmp_b)                            iCmp_res = 3'b010;
        else                                                  iCmp_res = 3'b100;
    end

    // Per-run observations: cycle of oDone (counted in negedges after the start edge), cascade per cycle.
    int         done_cyc;
    int         busy_cnt;
    logic [2:0] cas_log [1:8];
    logic [2:0] data_at_done;
    logic       err_at_done;

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge iClk);
        iData_a = a;
        iData_b = b;
        iStart  = 1'b1;
        @(posedge iClk);
        #1 iStart = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        done_cyc = 0;
        busy_cnt = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge iClk);
            if (c <= 8) cas_log[c] = oCmp_cas;
            if (oBusy) busy_cnt++;
            if (oDone) begin
                done_cyc     = c;
                data_at_done = oData;
                err_at_done  = oErr;
                break;
            end
        end
    endtask

    task automatic test_reset;
        iRst = 1'b1; iStart = 1'b0; iData_a = '0; iData_b = '0;
        repeat (3) @(posedge iClk);
        #1 iRst = 1'b0;
        @(negedge iClk);
        checks++;
        if ({oBusy, oDone, oData, oErr, oCmp_a, oCmp_b, oCmp_cas} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {oBusy, oDone, oData, oErr, oCmp_a, oCmp_b, oCmp_cas});
        end
    endtask

    task automatic test_equal;
        start_op(16'h1234, 16'h1234);
        wait_done(20);
        checks++;
        if (done_cyc !== 6) begin failures++; $display("FAIL eq_latency got=%0d want=6", done_cyc); end
        checks++;
        if (data_at_done !== 3'b010) begin failures++; $display("FAIL eq_data got=%b want=010", data_at_done); end
        checks++;
        if (err_at_done !== 1'b0) begin failures++; $display("FAIL eq_err got=%b want=0", err_at_done); end
        checks++;
        if (busy_cnt !== 5) begin failures++; $display("FAIL eq_busy_cycles got=%0d want=5", busy_cnt); end
        repeat (3) @(negedge iClk);
        checks++;
        if (oData !== 3'b010 || oDone !== 1'b0) begin
            failures++; $display("FAIL eq_hold got data=%b done=%b want data=010 done=0", oData, oDone);
        end
    endtask

    task automatic test_msb_decides;
        start_op(16'h8000, 16'h7FFF);
        wait_done(20);
        checks++;
        if (data_at_done !== 3'b001) begin failures++; $display("FAIL msb_data got=%b want=001", data_at_done); end
`ifdef NIBBLE_CMP_EARLY_EXIT_EN
        checks++;
        if (done_cyc !== 3) begin failures++; $display("FAIL msb_latency got=%0d want=3", done_cyc); end
`else
        checks++;
        if (done_cyc !== 6) begin failures++; $display("FAIL msb_latency got=%0d want=6", done_cyc); end
        checks++;
        if ({cas_log[2], cas_log[3], cas_log[4], cas_log[5]} !== {3'b000, 3'b001, 3'b001, 3'b001}) begin
            failures++;
            $display("FAIL msb_cascade got=%b %b %b %b want=000 001 001 001", cas_log[2], cas_log[3], cas_log[4], cas_log[5]);
        end
`endif
    endtask

    task automatic test_lsb_decides;
        start_op(16'h12F0, 16'h12F1);
        wait_done(20);
        checks++;
        if (data_at_done !== 3'b100) begin failures++; $display("FAIL lsb_data got=%b want=100", data_at_done); end
        checks++;
        if (done_cyc !== 6) begin failures++; $display("FAIL lsb_latency got=%0d want=6", done_cyc); end
        checks++;
        if ({cas_log[2], cas_log[3], cas_log[4], cas_log[5]} !== 12'd0) begin
            failures++;
            $display("FAIL lsb_cascade got=%b %b %b %b want=000 000 000 000", cas_log[2], cas_log[3], cas_log[4], cas_log[5]);
        end
    endtask

    task automatic test_start_ignored;
        int pulses;
        int c;
        pulses = 0;
        @(negedge iClk);
        iData_a = 16'h8000; iData_b = 16'h7FFF; iStart = 1'b1;
        @(posedge iClk);
        #1 iData_a = 16'h0000; iData_b = 16'h0001;   // iStart stays high
        c = 0;
        while (c < 20 && pulses == 0) begin
            @(negedge iClk);
            c++;
            if (oDone) begin
                pulses++;
                data_at_done = oData;
                iStart = 1'b0;
            end
        end
        iStart = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge iClk);
            if (oDone) pulses++;
        end
        checks++;
        if (pulses !== 1) begin failures++; $display("FAIL ign_pulses got=%0d want=1", pulses); end
        checks++;
        if (data_at_done !== 3'b001) begin failures++; $display("FAIL ign_data got=%b want=001", data_at_done); end
    endtask

    task automatic test_mid_reset;
        int pulses;
        pulses = 0;
        start_op(16'h0001, 16'h0002);
        repeat (3) @(negedge iClk);                     // now in second RUN cycle
        iRst = 1'b1;
        @(posedge iClk);
        #1 iRst = 1'b0;
        @(negedge iClk);
        checks++;
        if ({oBusy, oDone, oData, oCmp_cas} !== 6'd0) begin
            failures++; $display("FAIL rst_mid got busy=%b done=%b data=%b cas=%b want all 0", oBusy, oDone, oData, oCmp_cas);
        end
        for (int k = 0; k < 8; k++) begin
            if (oDone) pulses++;
            @(negedge iClk);
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL rst_no_done got=%0d want=0", pulses); end
        start_op(16'h00FF, 16'h00FE);
        wait_done(20);
        checks++;
        if (done_cyc !== 6 || data_at_done !== 3'b001) begin
            failures++; $display("FAIL rst_restart got cyc=%0d data=%b want cyc=6 data=001", done_cyc, data_at_done);
        end
    endtask

    task automatic test_error;
        fault_en = 1'b1;
        start_op(16'h1234, 16'h1234);
        wait_done(20);
        fault_en = 1'b0;
        checks++;
        if (err_at_done !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=1", err_at_done); end
        checks++;
        if (data_at_done !== 3'b011) begin failures++; $display("FAIL err_data got=%b want=011", data_at_done); end
        start_op(16'h5555, 16'h5555);
        @(negedge iClk);
        checks++;
        if (oErr !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want=0", oErr); end
        wait_done(20);
        checks++;
        if (err_at_done !== 1'b0 || data_at_done !== 3'b010) begin
            failures++; $display("FAIL err_next got err=%b data=%b want err=0 data=010", err_at_done, data_at_done);
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb_decides();
        test_lsb_decides();
        test_start_ignored();
        test_mid_reset();
        test_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
